sha2_core: RTL
==============

// Module: sha2_core
// PURPOSE
//  Parametrised SHA-2 compression engine covering the SHA-256 family (WORD=32) and SHA-512 family (WORD=64).
//  Takes one padded message block per valid/ready handshake, chains blocks internally, returns the digest.
//  Message schedule uses a rolling 16-word window computed on the fly (no full W array). One round per cycle.
//  Sits between the padding/framing front end and the digest consumer in the hash subsystem.
// PARAMETERS
//  WORD    64  word width; 32 -> SHA-256 family (64 rounds), 64 -> SHA-512 family (80 rounds); other values illegal
//  ROUNDS  derived (WORD==64 ? 80 : 64), localparam, not overridable
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         asynchronous, active-high reset
//  in_valid   in   1         block/first/mode valid
//  in_ready   out  1         core can accept a block (state IDLE)
//  in_block   in   16*WORD   padded block; W[i] = in_block[i*WORD +: WORD], W[0] in LSBs
//  in_first   in   1         1: start from mode IV; 0: continue from chaining register
//  in_mode    in   2         WORD=64: 0 512/224, 1 512/256, 2 384, 3 512; WORD=32: bit0 0 224, 1 256; bit1 ignored
//  out_valid  out  1         digest valid, held until accepted
//  out_ready  in   1         consumer accepts digest
//  out_digest out  8*WORD    {a,b,c,d,e,f,g,h}, a in MSBs; stable while out_valid
// BEHAVIOUR
//  States: IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE), combinational from state only.
//  Reset (async, any state incl. mid-RUN): state IDLE, iter 0, out_valid 0, out_digest 0, chaining reg H 0,
//   working regs a..h 0, window 0. In-flight block discarded, no output produced.
//  IDLE: on in_valid&in_ready edge E0: H <= in_first ? IV(in_mode) : H; a..h <= same value;
//   window <= W[0..15]; latch mode; iter <= 0; -> RUN. in_valid without ready is a no-op.
//  RUN: edges E1..E_ROUNDS execute rounds t=0..ROUNDS-1 with W[t] = window[0], K[t];
//   window shifts by one, new entry = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t] (all mod 2^WORD).
//   At round ROUNDS-1: -> DONE.
//  DONE entry (edge E_ROUNDS+1): H <= H + {a..h} per word mod 2^WORD; out_digest <= that sum; out_valid <= 1.
//   Latency accept edge -> out_valid high: ROUNDS+1 cycles (65 for WORD=32, 81 for WORD=64).
//  DONE: hold out_valid/out_digest until out_valid&out_ready edge; then out_valid <= 0, -> IDLE.
//   No new block accepted in DONE (no overlap). out_digest keeps last value after handshake.
//  out_ready asserted before out_valid has no effect; handshake in same cycle out_valid rises is legal.
//  Sigma functions: WORD=64 Σ0 28/34/39, Σ1 14/18/41, σ0 1/8/>>7, σ1 19/61/>>6;
//   WORD=32 Σ0 2/13/22, Σ1 6/11/25, σ0 7/18/>>3, σ1 17/19/>>10. All additions wrap modulo 2^WORD.
//  in_first=0 directly after reset chains from zero H: defined, no error flag.
//  in_mode/in_first sampled only at accept edge; changes elsewhere ignored.
// CONFIGURATION
//  SHA2_DIGEST_TRUNC_EN defined: out_digest bits below the mode's digest length (counted from MSB) forced to 0
//   (224: keep 224 MSBs; 256: 256; 384: 384; 512: all). Chaining register H is never truncated.
//  Not defined: out_digest is the full 8*WORD chaining state for every mode.
// TESTING
//  WORD=32, mode 1, first=1, "abc" block (W0=32'h61626380, W15=32'h18) -> 65 cycles later out_digest
//   ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  WORD=64, mode 3, "abc" (W0=64'h6162638000000000, W15=64'h18) -> 81 cycles later ddaf35a193617aba
//   cc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f.
//  WORD=64, mode 2, "abc" -> top 384 bits cb00753f45a35e8bb5a03d699ac65007272c32ab0eded163
//   1a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7; with SHA2_DIGEST_TRUNC_EN low 128 bits == 0.
//  WORD=32, two blocks "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first=1 then 0)
//   -> final digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  Backpressure: out_ready low 20 cycles after out_valid -> out_valid/out_digest stable, in_ready stays 0,
//   in_valid pulses ignored; accept -> IDLE next cycle, in_ready 1.
//  Assert rst at round 30 -> out_valid 0, in_ready 1, digest 0; new "abc" block afterwards gives correct digest.

Source files
------------

// File: rtl/sha2_core.sv
// SHA-2 compression engine (WORD=32: SHA-224/256, WORD=64: SHA-384/512/224/256), one round per clock.
// Optional SHA2_DIGEST_TRUNC_EN zeroes out_digest bits below the selected mode's digest length.
module sha2_core #(
  parameter int WORD = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORD-1:0]   in_block,
  input  logic                 in_first,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORD-1:0]    out_digest,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid, once raised,
  // holds with stable payload until that edge, and ready never depends on valid.

  localparam int ROUNDS = (WORD == 64) ? 80 : 64;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  localparam int BS0A = (WORD == 64) ? 28 : 2;
  localparam int BS0B = (WORD == 64) ? 34 : 13;
  localparam int BS0C = (WORD == 64) ? 39 : 22;
  localparam int BS1A = (WORD == 64) ? 14 : 6;
  localparam int BS1B = (WORD == 64) ? 18 : 11;
  localparam int BS1C = (WORD == 64) ? 41 : 25;
  localparam int SS0A = (WORD == 64) ? 1  : 7;
  localparam int SS0B = (WORD == 64) ? 8  : 18;
  localparam int SS0C = (WORD == 64) ? 7  : 3;
  localparam int SS1A = (WORD == 64) ? 19 : 17;
  localparam int SS1B = (WORD == 64) ? 61 : 19;
  localparam int SS1C = (WORD == 64) ? 6  : 10;

  // SHA-256 constants are the upper halves of the SHA-512 ones, so one table serves both.
  localparam logic [63:0] K_TAB [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Rows: 512/224, 512/256, 384, 512. SHA-224/256 IVs are the low/high halves of the 384/512 rows.
  localparam logic [63:0] IV_TAB [32] = '{
    64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
    64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1,
    64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
    64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2,
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4,
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [6:0]          r_iter;
  logic [1:0]          r_mode;
  logic                r_out_valid;
  logic [8*WORD-1:0]   r_digest;
  logic [WORD-1:0]     r_chain [8];
  logic [WORD-1:0]     r_v     [8];
  logic [WORD-1:0]     r_win   [16];

  logic [WORD-1:0]     w_iv    [8];
  logic [WORD-1:0]     w_start [8];
  logic [WORD-1:0]     w_sum   [8];
  logic [8*WORD-1:0]   w_sum_flat;
  logic [8*WORD-1:0]   w_mask;
  logic [1:0]          w_iv_sel;
  logic [63:0]         w_iv_raw;
  logic [63:0]         w_k64;
  logic [WORD-1:0]     w_k;
  logic [WORD-1:0]     w_ch;
  logic [WORD-1:0]     w_maj;
  logic [WORD-1:0]     w_t1;
  logic [WORD-1:0]     w_t2;
  logic [WORD-1:0]     w_wnew;

  function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int n);
    return (x >> n) | (x << (WORD - n));
  endfunction

  function automatic logic [WORD-1:0] bsig0(input logic [WORD-1:0] x);
    return rotr(x, BS0A) ^ rotr(x, BS0B) ^ rotr(x, BS0C);
  endfunction

  function automatic logic [WORD-1:0] bsig1(input logic [WORD-1:0] x);
    return rotr(x, BS1A) ^ rotr(x, BS1B) ^ rotr(x, BS1C);
  endfunction

  function automatic logic [WORD-1:0] ssig0(input logic [WORD-1:0] x);
    return rotr(x, SS0A) ^ rotr(x, SS0B) ^ (x >> SS0C);
  endfunction

  function automatic logic [WORD-1:0] ssig1(input logic [WORD-1:0] x);
    return rotr(x, SS1A) ^ rotr(x, SS1B) ^ (x >> SS1C);
  endfunction

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_digest = r_digest;
  assign dbg_state  = r_state;

  always_comb begin
    w_iv_sel = (WORD == 64) ? in_mode : (in_mode[0] ? 2'd3 : 2'd2);
    w_iv_raw = '0;
    for (int i = 0; i < 8; i++) begin
      w_iv_raw = IV_TAB[{w_iv_sel, 3'(i)}];
      if (WORD == 32 && !in_mode[0]) w_iv_raw = {w_iv_raw[31:0], 32'h0};
      w_iv[i]    = w_iv_raw[63 -: WORD];
      w_start[i] = in_first ? w_iv[i] : r_chain[i];
    end
  end

  always_comb begin
    w_k64  = K_TAB[r_iter];
    w_k    = w_k64[63 -: WORD];
    w_ch   = (r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]);
    w_maj  = (r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]);
    w_t1   = r_v[7] + bsig1(r_v[4]) + w_ch + w_k + r_win[0];
    w_t2   = bsig0(r_v[0]) + w_maj;
    w_wnew = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];
  end

  always_comb begin
    w_sum_flat = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum[i] = r_chain[i] + r_v[i];
      w_sum_flat[(7-i)*WORD +: WORD] = w_sum[i];
    end
  end

`ifdef SHA2_DIGEST_TRUNC_EN
  int w_keep;
  always_comb begin
    w_keep = 8 * WORD;
    if (WORD == 64) begin
      case (r_mode)
        2'd0:    w_keep = 224;
        2'd1:    w_keep = 256;
        2'd2:    w_keep = 384;
        default: w_keep = 512;
      endcase
    end else begin
      w_keep = r_mode[0] ? 256 : 224;
    end
    w_mask = ~({(8*WORD){1'b1}} >> w_keep);
  end
`else
  assign w_mask = '1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_RUN;
      ST_RUN:  if (r_iter == LAST) w_next = ST_DONE;
      ST_DONE: if (r_out_valid && out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter      <= '0;
      r_mode      <= '0;
      r_out_valid <= 1'b0;
      r_digest    <= '0;
      for (int i = 0; i < 8; i++) begin
        r_chain[i] <= '0;
        r_v[i]     <= '0;
      end
      for (int j = 0; j < 16; j++) r_win[j] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 8; i++) begin
              r_chain[i] <= w_start[i];
              r_v[i]     <= w_start[i];
            end
            for (int j = 0; j < 16; j++) r_win[j] <= in_block[j*WORD +: WORD];
            r_mode <= in_mode;
            r_iter <= '0;
          end
        end
        ST_RUN: begin
          r_v[0] <= w_t1 + w_t2;
          r_v[1] <= r_v[0];
          r_v[2] <= r_v[1];
          r_v[3] <= r_v[2];
          r_v[4] <= r_v[3] + w_t1;
          r_v[5] <= r_v[4];
          r_v[6] <= r_v[5];
          r_v[7] <= r_v[6];
          for (int j = 0; j < 15; j++) r_win[j] <= r_win[j+1];
          r_win[15] <= w_wnew;
          r_iter    <= (r_iter == LAST) ? 7'd0 : r_iter + 7'd1;
        end
        ST_DONE: begin
          // First DONE cycle folds the working state into H; later cycles only wait for the consumer.
          if (!r_out_valid) begin
            for (int i = 0; i < 8; i++) r_chain[i] <= w_sum[i];
            r_digest    <= w_sum_flat & w_mask;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
